// File: rtl/hazard_pkg.sv
// Shared widths, encodings and stage indices for the hazard/forwarding block.
package hazard_pkg;

  // Register-address width for a register file of num_regs entries.
  function automatic int ra_w(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  // Width of a forwarding select: 0 = regfile, 1..fwd_stages = stage index + 1.
  function automatic int fs_w(input int fwd_stages);
    return (fwd_stages > 0) ? $clog2(fwd_stages + 1) : 1;
  endfunction

  // Width of the in-flight multi-cycle op counter (must hold 0..mc_slots).
  function automatic int mc_w(input int mc_slots);
    return (mc_slots > 0) ? $clog2(mc_slots + 1) : 1;
  endfunction

  localparam int FWD_NONE = 0;  // operand comes from the register file
  localparam int STG_MEM  = 0;  // youngest forwarding stage
  localparam int STG_WB   = 1;  // next-older forwarding stage

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard for variable-latency ops: one bit per register plus
// an outstanding-op counter. A set and a clear of the same register in one
// cycle leaves it set; writebacks with nothing outstanding are dropped.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int NUM_REGS = 32,
  parameter  int MC_SLOTS = 2,
  localparam int RA_W     = ra_w(NUM_REGS),
  localparam int IW       = mc_w(MC_SLOTS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue,
  input  logic [RA_W-1:0]     issue_rd,
  input  logic                wb_valid,
  input  logic [RA_W-1:0]     wb_rd,
  output logic [NUM_REGS-1:0] pending,
  output logic [IW-1:0]       inflight
);

  logic [NUM_REGS-1:0] pending_r;
  logic [NUM_REGS-1:0] pending_nxt_s;
  logic [NUM_REGS-1:0] set_mask_s;
  logic [NUM_REGS-1:0] clr_mask_s;
  logic [IW-1:0]       inflight_r;
  logic [IW-1:0]       inflight_nxt_s;
  logic                inc_s;
  logic                dec_s;

  // A writeback only counts when something is outstanding; issue never overfills.
  assign dec_s = wb_valid && (inflight_r != '0);
  assign inc_s = issue && (inflight_r < IW'(MC_SLOTS));

  // Next-state of pending bits and counter; set mask applied after clear so set wins.
  always_comb begin
    set_mask_s     = '0;
    clr_mask_s     = '0;
    inflight_nxt_s = inflight_r;
    if (dec_s) clr_mask_s[wb_rd] = 1'b1;
    else       clr_mask_s        = '0;
    if (issue && (issue_rd != '0)) set_mask_s[issue_rd] = 1'b1;
    else                           set_mask_s           = '0;
    pending_nxt_s    = (pending_r & ~clr_mask_s) | set_mask_s;
    pending_nxt_s[0] = 1'b0;
    case ({inc_s, dec_s})
      2'b10:   inflight_nxt_s = inflight_r + IW'(1);
      2'b01:   inflight_nxt_s = inflight_r - IW'(1);
      default: inflight_nxt_s = inflight_r;
    endcase
  end

  // Scoreboard state registers; reset discards every in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r  <= '0;
      inflight_r <= '0;
    end else begin
      pending_r  <= pending_nxt_s;
      inflight_r <= inflight_nxt_s;
    end
  end

  assign pending  = pending_r;
  assign inflight = inflight_r;

endmodule

// File: rtl/hazard_fwd_scoreboard.sv
// EX operand forwarding, ID load-use / scoreboard stall detection and a
// saturating stall-cycle counter. The scoreboard is read registered, so a
// writeback releases a dependent stall one cycle after it happens.
module hazard_fwd_scoreboard
  import hazard_pkg::*;
#(
  parameter  int NUM_REGS   = 32,
  parameter  int NUM_READ   = 2,
  parameter  int FWD_STAGES = 2,
  parameter  int MC_SLOTS   = 2,
  parameter  int CNT_W      = 16,
  localparam int RA_W       = ra_w(NUM_REGS),
  localparam int FS_W       = fs_w(FWD_STAGES),
  localparam int IW         = mc_w(MC_SLOTS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_READ-1:0][RA_W-1:0]    ex_rs,
  input  logic [FWD_STAGES-1:0][RA_W-1:0]  stage_rd,
  input  logic [FWD_STAGES-1:0]            stage_reg_wr,
  output logic [NUM_READ-1:0][FS_W-1:0]    forward_sel,
  input  logic [NUM_READ-1:0][RA_W-1:0]    id_rs,
  input  logic [NUM_READ-1:0]              id_rs_used,
  input  logic [RA_W-1:0]                  id_rd,
  input  logic                             id_valid,
  input  logic                             id_mc_op,
  input  logic [RA_W-1:0]                  ex_rd,
  input  logic                             ex_mem_read,
  input  logic                             mc_wb_valid,
  input  logic [RA_W-1:0]                  mc_wb_rd,
  output logic                             stall_id,
  output logic                             flush_ex,
  output logic [NUM_REGS-1:0]              sb_pending,
  output logic [IW-1:0]                    mc_inflight,
  output logic [CNT_W-1:0]                 stall_count
);

  logic [NUM_READ-1:0][FWD_STAGES-1:0] hit_s;
  logic                                load_use_s;
  logic                                raw_s;
  logic                                waw_s;
  logic                                struct_s;
  logic                                issue_s;
  logic [CNT_W-1:0]                    stall_cnt_r;

  // Forward select: scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    hit_s       = '0;
    forward_sel = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      forward_sel[i] = FS_W'(FWD_NONE);
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
        hit_s[i][k]    = stage_reg_wr[k] && (stage_rd[k] != '0) && (stage_rd[k] == ex_rs[i]);
        forward_sel[i] = hit_s[i][k] ? FS_W'(k + 1) : forward_sel[i];
      end
    end
  end

  // Per-source hazard terms: load-use against EX and RAW against the scoreboard.
  always_comb begin
    load_use_s = 1'b0;
    raw_s      = 1'b0;
    for (int i = 0; i < NUM_READ; i++) begin
      load_use_s = load_use_s | (ex_mem_read && (ex_rd != '0) && (ex_rd == id_rs[i]) && id_rs_used[i]);
      raw_s      = raw_s | (sb_pending[id_rs[i]] && id_rs_used[i]);
    end
  end

  assign waw_s    = sb_pending[id_rd] && (id_rd != '0);
  assign struct_s = id_mc_op && (mc_inflight == IW'(MC_SLOTS));
  assign stall_id = id_valid && (load_use_s || raw_s || waw_s || struct_s);
  assign flush_ex = stall_id;
  assign issue_s  = id_valid && id_mc_op && !stall_id;

  hazard_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .MC_SLOTS (MC_SLOTS)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue    (issue_s),
    .issue_rd (id_rd),
    .wb_valid (mc_wb_valid),
    .wb_rd    (mc_wb_rd),
    .pending  (sb_pending),
    .inflight (mc_inflight)
  );

  // Saturating count of cycles spent stalling ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= '0;
    end else if (stall_id && (stall_cnt_r != '1)) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_count = stall_cnt_r;

endmodule
